// File: rtl/lane_channel_pkg.sv
// lane_channel_pkg: shared types and constants for the lane channel model.
//   lane_state_e : RUN / SETTLE channel state
//   LFSR_SEED    : reset value of the error-injection LFSR
//   LFSR_TAPS    : feedback mask for x^16+x^14+x^13+x^11+1
//   lfsr_step()  : one Fibonacci shift of the 16-bit LFSR
package lane_channel_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    SETTLE = 1'b1
  } lane_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // bits 15,13,12,10 correspond to polynomial terms x^16, x^14, x^13, x^11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lane_lfsr16.sv
// lane_lfsr16: free-running 16-bit maximal-length LFSR used as the
// pseudo-random source for bit-error injection.
//   clk  : bit clock
//   res  : synchronous active-high reset, reloads LFSR_SEED
//   lfsr : current LFSR state, advances every cycle while res=0
module lane_lfsr16
  import lane_channel_pkg::*;
(
  input  logic        clk,
  input  logic        res,
  output logic [15:0] lfsr
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (res) r_lfsr <= LFSR_SEED;
    else     r_lfsr <= lfsr_step(r_lfsr);
  end

  assign lfsr = r_lfsr;

endmodule

// File: rtl/lane_channel_model.sv
// lane_channel_model: behavioral serial lane between a serializer and its
// consumer. Applies a configurable delay, optional inversion and optional
// pseudo-random bit-error injection. A delay change drains the line for
// max(old,new)+1 cycles with the output forced low.
//
// Build option: define LANE_CHANNEL_ERR_INJ_EN to build the LFSR, flip logic
// and error counter; otherwise flips never happen and err_count is 0.
//
// Ports:
//   clk, res              : bit clock, synchronous active-high reset
//   data_in               : serial input bit
//   cfg_valid / cfg_ready : configuration handshake (ready only in RUN)
//   cfg_delay             : lane delay in cycles (latency = delay+1)
//   cfg_polarity          : 1 inverts data_out
//   cfg_err_thresh        : flip when lfsr[7:0] < thresh; 0 disables
//   data_out              : registered output bit
//   settling              : high while a delay change drains
//   err_count             : saturating count of injected flips
module lane_channel_model
  import lane_channel_pkg::*;
#(
  parameter int LOG_DELAY = 5,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 data_in,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [LOG_DELAY-1:0] cfg_delay,
  input  logic                 cfg_polarity,
  input  logic [7:0]           cfg_err_thresh,
  output logic                 data_out,
  output logic                 settling,
  output logic [CNT_W-1:0]     err_count
);

  localparam int DEPTH = 2**LOG_DELAY;
  localparam logic [LOG_DELAY:0] CNT_ONE = {{LOG_DELAY{1'b0}}, 1'b1};

  logic [DEPTH-1:0]     r_hist;
  logic [DEPTH-1:0]     w_hist_nxt;
  lane_state_e          r_state, w_state_nxt;
  logic [LOG_DELAY:0]   r_cnt;
  logic [LOG_DELAY-1:0] r_cur_delay;
  logic                 r_cur_pol;
  logic                 r_out;
  logic                 w_xfer;
  logic                 w_flip;
  logic [LOG_DELAY-1:0] w_max_delay;
  logic                 w_unused_hist;

  assign w_xfer = cfg_valid && cfg_ready;

  // The output register taps the history as it will look after this edge,
  // so delay 0 means data_in appears on data_out one cycle later and
  // data_out always equals the registered hist[cur_delay].
  assign w_hist_nxt = {r_hist[DEPTH-2:0], data_in};

  // Oldest bit keeps the history 2**LOG_DELAY deep but is never tapped,
  // because the tap reads one stage ahead of the register.
  assign w_unused_hist = r_hist[DEPTH-1];

  always_ff @(posedge clk) begin
    if (res) r_hist <= '0;
    else     r_hist <= w_hist_nxt;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (res) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:    if (w_xfer && (cfg_delay != r_cur_delay)) w_state_nxt = SETTLE;
      SETTLE: if (r_cnt <= CNT_ONE)                      w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    cfg_ready = (r_state == RUN);
    settling  = (r_state == SETTLE);
  end

  // Drain length: long enough for every bit under either delay to clear.
  assign w_max_delay = (cfg_delay > r_cur_delay) ? cfg_delay : r_cur_delay;

  always_ff @(posedge clk) begin
    if (res)
      r_cnt <= '0;
    else if (r_state == RUN && w_state_nxt == SETTLE)
      r_cnt <= {1'b0, w_max_delay} + CNT_ONE;
    else if (r_state == SETTLE)
      r_cnt <= r_cnt - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_cur_delay <= '0;
      r_cur_pol   <= 1'b0;
    end else if (w_xfer) begin
      r_cur_delay <= cfg_delay;
      r_cur_pol   <= cfg_polarity;
    end
  end

  // ---------------- error injection ----------------
`ifdef LANE_CHANNEL_ERR_INJ_EN
  logic [15:0]      w_lfsr;
  logic [7:0]       r_cur_thresh;
  logic [CNT_W-1:0] r_err_cnt;
  logic             w_unused_lfsr;

  lane_lfsr16 u_lfsr (
    .clk  (clk),
    .res  (res),
    .lfsr (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[15:8];

  always_ff @(posedge clk) begin
    if (res)         r_cur_thresh <= '0;
    else if (w_xfer) r_cur_thresh <= cfg_err_thresh;
  end

  assign w_flip = (r_state == RUN) && (w_lfsr[7:0] < r_cur_thresh);

  always_ff @(posedge clk) begin
    if (res)
      r_err_cnt <= '0;
    else if (w_flip && (r_err_cnt != {CNT_W{1'b1}}))
      r_err_cnt <= r_err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign err_count = r_err_cnt;
`else
  logic w_unused_thresh;
  assign w_unused_thresh = ^cfg_err_thresh;
  assign w_flip          = 1'b0;
  assign err_count       = '0;
`endif

  // ---------------- output register ----------------
  // Gated on the next state so data_out is low exactly while settling is high.
  always_ff @(posedge clk) begin
    if (res)
      r_out <= 1'b0;
    else if (w_state_nxt == RUN)
      r_out <= w_hist_nxt[r_cur_delay] ^ r_cur_pol ^ w_flip;
    else
      r_out <= 1'b0;
  end

  assign data_out = r_out;

endmodule

// File: tb/tb_lane_channel_model.sv
// Self-checking bench for lane_channel_model: scoreboard of expected output
// bits, each tagged with the edge at which it must appear on data_out.
module tb_lane_channel_model;

  localparam int LOG_DELAY = 5;
  localparam int CNT_W     = 10;

  logic                 clk = 1'b0;
  logic                 res;
  logic                 data_in;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [LOG_DELAY-1:0] cfg_delay;
  logic                 cfg_polarity;
  logic [7:0]           cfg_err_thresh;
  logic                 data_out;
  logic                 settling;
  logic [CNT_W-1:0]     err_count;

  lane_channel_model #(.LOG_DELAY(LOG_DELAY), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .res            (res),
    .data_in        (data_in),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_delay      (cfg_delay),
    .cfg_polarity   (cfg_polarity),
    .cfg_err_thresh (cfg_err_thresh),
    .data_out       (data_out),
    .settling       (settling),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   due;
    logic val;
    logic zero;
  } exp_t;

  exp_t exp_q[$];
  logic exp_pol = 1'b0;
  int   mdl_delay = 0;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int due, input logic v, input logic z);
    exp_t e;
    e.due  = due;
    e.val  = v;
    e.zero = z;
    exp_q.push_back(e);
  endtask

  // one bit clock: drive, take the edge, sample 1 time unit later
  task automatic tick(input logic d);
    data_in = d;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("dout", data_out, e.zero ? 1'b0 : (e.val ^ exp_pol));
    end
  endtask

  // drive a bit and record where it must reappear
  task automatic send(input logic d);
    push(cyc + 1 + mdl_delay, d, 1'b0);
    tick(d);
  endtask

  int   t0, e0, e1, ones;
  logic b;

  initial begin
    res = 1'b1; data_in = 1'b0; cfg_valid = 1'b0;
    cfg_delay = '0; cfg_polarity = 1'b0; cfg_err_thresh = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", data_out, 0);
    chk("rst_settling", settling, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ready", cfg_ready, 1);
    res = 1'b0;

    // delay 0, polarity 0: one-cycle latency
    mdl_delay = 0;
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    for (int i = 0; i < 16; i++) send(1'($urandom_range(1)));
    chk("d0_err", err_count, 0);

    // delay 0 -> 7 with inversion: 8 settle cycles, then 8-cycle latency
    chk("ready_pre", cfg_ready, 1);
    cfg_delay = 5'd7; cfg_polarity = 1'b1; cfg_valid = 1'b1;
    t0 = cyc + 1;
    for (int k = 0; k < 8; k++) push(t0 + k, 1'b0, 1'b1);
    tick(1'($urandom_range(1)));
    cfg_valid = 1'b0;
    exp_pol = 1'b1;
    mdl_delay = 7;
    chk("settle_on", settling, 1);
    chk("ready_off", cfg_ready, 0);
    for (int k = 1; k < 8; k++) begin
      send(1'($urandom_range(1)));
      chk("settle_hold", settling, 1);
      chk("ready_hold", cfg_ready, 0);
    end
    send(1'($urandom_range(1)));
    chk("settle_done", settling, 0);
    chk("ready_back", cfg_ready, 1);
    for (int i = 0; i < 24; i++) send(1'($urandom_range(1)));

    // same delay, polarity back to 0: no settle
    cfg_delay = 5'd7; cfg_polarity = 1'b0; cfg_valid = 1'b1;
    send(1'($urandom_range(1)));
    cfg_valid = 1'b0;
    exp_pol = 1'b0;
    chk("nosettle", settling, 0);
    chk("ready_stay", cfg_ready, 1);
    for (int i = 0; i < 16; i++) begin
      send(1'($urandom_range(1)));
      chk("ready_run", cfg_ready, 1);
    end
    // fill history with zeros and drain the scoreboard
    for (int i = 0; i < 8; i++) send(1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0);

`ifdef LANE_CHANNEL_ERR_INJ_EN
    cfg_err_thresh = 8'hFF; cfg_valid = 1'b1;
    tick(1'b0);
    cfg_valid = 1'b0;
    e0 = int'(err_count);
    ones = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1'b0);
      ones += int'(data_out);
    end
    e1 = int'(err_count);
    chk("inj_ones_eq_cnt", ones, e1 - e0);
    chk("inj_ratio", (ones >= 960 && ones <= 1000), 1);

    cfg_err_thresh = 8'h00; cfg_valid = 1'b1;
    tick(1'b0);
    cfg_valid = 1'b0;
    e0 = int'(err_count);
    ones = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1'b0);
      ones += int'(data_out);
    end
    chk("thr0_cnt", err_count, e0);
    chk("thr0_ones", ones, 0);

    cfg_err_thresh = 8'hFF; cfg_valid = 1'b1;
    tick(1'b0);
    cfg_valid = 1'b0;
    for (int i = 0; i < 200; i++) tick(1'b0);
    chk("err_sat", err_count, {CNT_W{1'b1}});
`else
    cfg_err_thresh = 8'hFF; cfg_valid = 1'b1;
    tick(1'b0);
    cfg_valid = 1'b0;
    ones = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1'b0);
      ones += int'(data_out);
    end
    chk("noinj_cnt", err_count, 0);
    chk("noinj_ones", ones, 0);
`endif
    cfg_err_thresh = 8'h00; cfg_valid = 1'b1;
    tick(1'b0);
    cfg_valid = 1'b0;
    exp_q.delete();

    // reset during the third settle cycle of a 7 -> 2 change
    cfg_delay = 5'd2; cfg_polarity = 1'b1; cfg_valid = 1'b1;
    tick(1'b1);
    cfg_valid = 1'b0;
    tick(1'b0);
    tick(1'b1);
    chk("rs_in_settle", settling, 1);
    res = 1'b1;
    tick(1'b1);
    res = 1'b0;
    chk("rs_ready", cfg_ready, 1);
    chk("rs_settle", settling, 0);
    chk("rs_dout", data_out, 0);
    chk("rs_err", err_count, 0);
    // delay back to 0 and polarity 0 after reset
    exp_pol = 1'b0;
    mdl_delay = 0;
    for (int i = 0; i < 12; i++) begin
      b = 1'($urandom_range(1));
      send(b);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lane_channel_model.md
LANE_CHANNEL_MODEL -- requirements
Module: lane_channel_model

Interface
REQ-001 Parameter LOG_DELAY, default 5: width of the delay select; the history depth is 2**LOG_DELAY bits.
REQ-002 Parameter CNT_W, default 16: width of the injected-error counter.
REQ-003 clk  input  1: single clock, the serial bit clock; all state updates on the rising edge.
REQ-004 res  input  1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 data_in  input  1: serial bit from the upstream behavioral serializer, one bit per cycle.
REQ-006 cfg_valid  input  1: a configuration request is presented.
REQ-007 cfg_ready  output  1: the block accepts a configuration on this cycle.
REQ-008 cfg_delay  input  LOG_DELAY: requested lane delay in cycles.
REQ-009 cfg_polarity  input  1: requested lane inversion; 1 inverts data_out.
REQ-010 cfg_err_thresh  input  8: requested bit-error injection threshold; 0 disables injection.
REQ-011 data_out  output  1: routed serial bit toward the HMC model or the deserializer.
REQ-012 settling  output  1: high while a delay change is draining.
REQ-013 err_count  output  CNT_W: number of injected bit flips.

Function
REQ-014 The block shall shift data_in into a 2**LOG_DELAY-bit history register every cycle, including while SETTLE is active.
REQ-015 In RUN, data_out shall be registered as hist[cur_delay] XOR cur_polarity XOR flip, with hist[0] holding the previous cycle's data_in.
REQ-016 Total latency from data_in to data_out shall be cur_delay+1 cycles; cur_delay=0 gives 1 cycle.
REQ-017 The FSM shall have exactly two states, RUN and SETTLE; cfg_ready shall equal (state==RUN).
REQ-018 A transfer occurs when cfg_valid && cfg_ready; cfg_delay, cfg_polarity and cfg_err_thresh shall then be latched into the cur_* registers in that cycle.
REQ-019 On a transfer with cfg_delay equal to cur_delay, the FSM shall stay in RUN; the new polarity and threshold shall apply from the next cycle.
REQ-020 On a transfer with cfg_delay different from cur_delay, the FSM shall enter SETTLE and load a counter with max(old,new)+1.
REQ-021 In SETTLE, data_out shall be forced to 0, settling shall be 1, no flips shall be injected, and the counter shall decrement each cycle.
REQ-022 When the counter reaches 0, the FSM shall return to RUN in the next cycle.
REQ-023 cfg_valid in SETTLE shall be ignored and held off by cfg_ready=0; the requester must hold cfg_valid and the config fields stable until accepted.
REQ-024 Every cycle, flip shall be 1 iff the error-injection feature is built in, state==RUN, and lfsr[7:0] < cur_err_thresh.
REQ-025 cur_err_thresh=0 shall never flip; 8'hFF shall flip on 255 of every 256 LFSR values.
REQ-026 err_count shall increment by 1 on each flip and saturate at all-ones without wrapping.

Reset
REQ-027 On res=1 at a clock edge, the following shall be cleared:
- history register, data_out, settling and err_count to 0;
- cur_delay, cur_polarity and cur_err_thresh to 0;
- state to RUN (cfg_ready=1 in the following cycle);
- LFSR to its seed.
REQ-028 Reset asserted during SETTLE shall abort the drain immediately, with no residual count.

Configuration
REQ-029 Macro LANE_CHANNEL_ERR_INJ_EN defined: the LFSR, the flip logic and the err_count counter shall be built as specified.
REQ-030 Macro LANE_CHANNEL_ERR_INJ_EN undefined: flip shall be constant 0, err_count shall be constant 0, cfg_err_thresh shall be ignored and no LFSR shall be instantiated.

Structure
REQ-031 Package lane_channel_pkg shall hold:
- the FSM state typedef (RUN, SETTLE);
- LFSR seed 16'hACE1;
- LFSR taps (x^16+x^14+x^13+x^11+1).
REQ-032 The LFSR shall be a sub-module lane_lfsr16 (clk, res, lfsr output) that advances every cycle while res=0.

Verification
REQ-033 Reset, delay 0, polarity 0, data_in = 1,0,1,1 -> data_out = 1,0,1,1 one cycle later; err_count=0.
REQ-034 Configure delay 7, polarity 1 from delay 0 -> settling=1 and data_out=0 for 8 cycles, cfg_ready=0 during that time; then data_out = inverted data_in at 8-cycle latency.
REQ-035 In RUN with delay 7, configure polarity 0 and delay 7 -> no SETTLE; data_out non-inverted from the next cycle; cfg_ready stays 1.
REQ-036 Macro defined, threshold 8'hFF, 1000 RUN cycles of data_in=0 -> ones on data_out equal the err_count increment; ratio of about 255/256. Threshold 0 -> err_count unchanged.
REQ-037 Force err_count to all-ones minus 1 with threshold 8'hFF -> saturates at all-ones.
REQ-038 res pulse at the 3rd SETTLE cycle -> next cycle shows state RUN, cfg_ready=1, data_out=0, cur_delay=0.
